// File: rtl/ex_unit.sv
// ex_unit: RV32I execute stage driving a registered register-file write port.
// Define MUL_EXT_EN to build the iterative shift-add multiplier used for MUL.
module ex_unit #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned MUL_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     inst_i,
   input  logic            inst_valid_i,
   output logic            inst_ready_o,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   output logic [4:0]      reg_waddr_o,
   output logic [XLEN-1:0] reg_wdata_o,
   output logic            reg_wen_o
);

   localparam logic [6:0] OpcOpImm = 7'b0010011;
   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] F7Base   = 7'b0000000;
   localparam logic [6:0] F7Alt    = 7'b0100000;

   logic [6:0]      opcode;
   logic [6:0]      funct7;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] src2;
   logic [4:0]      shamt;
   logic [XLEN-1:0] add_res;
   logic [XLEN-1:0] sub_res;
   logic [XLEN-1:0] sll_res;
   logic [XLEN-1:0] srl_res;
   logic [XLEN-1:0] sra_res;
   logic            lt_s;
   logic            lt_u;
   logic [XLEN-1:0] base_res;
   logic [XLEN-1:0] alu_res;
   logic            alu_ok;
   logic            accept;
   logic            unused_rs1;

   assign opcode = inst_i[6:0];
   assign rd     = inst_i[11:7];
   assign funct3 = inst_i[14:12];
   assign funct7 = inst_i[31:25];

   // rs1 index is resolved by the register file; only its value reaches this block.
   assign unused_rs1 = ^inst_i[19:15];

   assign imm   = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
   assign src2  = (opcode == OpcOp) ? op2_i : imm;
   assign shamt = src2[4:0];

   assign add_res = op1_i + src2;
   assign sub_res = op1_i - src2;
   assign sll_res = op1_i << shamt;
   assign srl_res = op1_i >> shamt;
   assign sra_res = $signed(op1_i) >>> shamt;
   assign lt_s    = $signed(op1_i) < $signed(src2);
   assign lt_u    = op1_i < src2;

   // Shared funct3 result for OP and OP-IMM; SUB is patched in by the decoder.
   always_comb begin
      base_res = '0;
      unique case (funct3)
         3'b000: base_res = add_res;
         3'b001: base_res = sll_res;
         3'b010: base_res = {{(XLEN-1){1'b0}}, lt_s};
         3'b011: base_res = {{(XLEN-1){1'b0}}, lt_u};
         3'b100: base_res = op1_i ^ src2;
         3'b101: base_res = inst_i[30] ? sra_res : srl_res;
         3'b110: base_res = op1_i | src2;
         3'b111: base_res = op1_i & src2;
      endcase
   end

`ifdef MUL_EXT_EN
   localparam logic [6:0]  F7Mul = 7'b0000001;
   localparam int unsigned CntW  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e          state_q;
   state_e          state_d;
   logic            is_mul;
   logic            mul_done;
   logic [CntW-1:0] cnt_q;
   logic [XLEN-1:0] acc_q;
   logic [XLEN-1:0] mcand_q;
   logic [XLEN-1:0] mplier_q;
   logic [XLEN-1:0] acc_step;
   logic [4:0]      mul_rd_q;
`endif

   always_comb begin
      alu_res = base_res;
      alu_ok  = 1'b0;
`ifdef MUL_EXT_EN
      is_mul  = 1'b0;
`endif
      case (opcode)
         OpcOpImm: begin
            case (funct3)
               3'b001:  alu_ok = (funct7 == F7Base);
               3'b101:  alu_ok = (funct7 == F7Base) || (funct7 == F7Alt);
               default: alu_ok = 1'b1;
            endcase
         end
         OpcOp: begin
            if (funct7 == F7Base) begin
               alu_ok = 1'b1;
            end else if (funct7 == F7Alt) begin
               if (funct3 == 3'b000) begin
                  alu_ok  = 1'b1;
                  alu_res = sub_res;
               end else if (funct3 == 3'b101) begin
                  alu_ok = 1'b1;
               end
            end
`ifdef MUL_EXT_EN
            else if ((funct7 == F7Mul) && (funct3 == 3'b000)) begin
               is_mul = 1'b1;
            end
`endif
         end
         default: ;
      endcase
   end

   assign accept = inst_valid_i && inst_ready_o;

`ifdef MUL_EXT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept && is_mul) state_d = StMul;
         StMul:  if (cnt_q == '0) state_d = StIdle;
      endcase
   end

   always_comb begin
      inst_ready_o = (state_q == StIdle);
      mul_done     = (state_q == StMul) && (cnt_q == '0);
   end

   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         mul_rd_q <= '0;
      end else if (accept && is_mul) begin
         cnt_q    <= CntW'(MUL_CYCLES - 1);
         acc_q    <= '0;
         mcand_q  <= op1_i;
         mplier_q <= op2_i;
         mul_rd_q <= rd;
      end else if (state_q == StMul) begin
         acc_q    <= acc_step;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
      end
   end
`else
   logic unused_cfg;

   assign inst_ready_o = 1'b1;
   assign unused_cfg   = (MUL_CYCLES != XLEN);
`endif

   // Illegal encodings leave the write port untouched; rd=0 still updates address/data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_wen_o   <= 1'b0;
         reg_waddr_o <= '0;
         reg_wdata_o <= '0;
      end else begin
         reg_wen_o <= 1'b0;
         if (accept && alu_ok) begin
            reg_waddr_o <= rd;
            reg_wdata_o <= alu_res;
            reg_wen_o   <= (rd != 5'd0);
         end
`ifdef MUL_EXT_EN
         else if (mul_done) begin
            reg_waddr_o <= mul_rd_q;
            reg_wdata_o <= acc_step;
            reg_wen_o   <= (mul_rd_q != 5'd0);
         end
`endif
      end
   end

endmodule

// File: tb/tb_ex_unit.sv
// Self-checking bench for ex_unit: vector table plus multi-cycle MUL/reset sequences,
// with a time-stamped scoreboard checked on every falling clock edge.
module tb_ex_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] inst = '0;
   logic        valid = 1'b0;
   logic        inst_ready_o;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;
   logic        reg_wen_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      time         t;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] op1;
      logic [31:0] op2;
      logic        push;
      logic        wen;
      logic [31:0] wdata;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];

   ex_unit dut (
      .clk          (clk),
      .rst          (rst),
      .inst_i       (inst),
      .inst_valid_i (valid),
      .inst_ready_o (inst_ready_o),
      .op1_i        (op1),
      .op2_i        (op2),
      .reg_waddr_o  (reg_waddr_o),
      .reg_wdata_o  (reg_wdata_o),
      .reg_wen_o    (reg_wen_o)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input time t, input logic wen, input logic [4:0] a,
                           input logic [31:0] d);
      exp_t e;
      e.t     = t;
      e.wen   = wen;
      e.waddr = a;
      e.wdata = d;
      sb.push_back(e);
   endtask

   task automatic add_vec(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                          input logic push, input logic wen, input logic [31:0] d);
      vec_t v;
      v.inst  = i;
      v.op1   = a;
      v.op2   = b;
      v.push  = push;
      v.wen   = wen;
      v.wdata = d;
      vecs.push_back(v);
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {imm, 5'd3, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
   endfunction

   // Drive at a falling edge, accept at the next rising edge, return on the next falling edge.
   task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                        input logic push, input logic wen, input logic [31:0] d);
      inst  = i;
      op1   = a;
      op2   = b;
      valid = 1'b1;
      chk("ready", 32'(inst_ready_o), 32'd1);
      @(posedge clk);
      if (push) push_exp($time + 5, wen, i[11:7], d);
      @(negedge clk);
   endtask

`ifdef MUL_EXT_EN
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      logic [31:0] prod;
      int n;
      prod  = a * b;
      inst  = enc_r(7'h01, 3'b000, rd);
      op1   = a;
      op2   = b;
      valid = 1'b1;
      chk("mul_ready_before", 32'(inst_ready_o), 32'd1);
      @(posedge clk);
      push_exp($time + 325, rd != 5'd0, rd, prod);
      @(negedge clk);
      // Held while busy; it must only be taken once the multiply has completed.
      inst = enc_i(12'h007, 3'b000, 5'd22);
      op1  = 32'h100;
      op2  = a;
      n = 0;
      while (!inst_ready_o && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("mul_busy_cycles", n, 32);
      @(posedge clk);
      push_exp($time + 5, 1'b1, 5'd22, 32'h107);
      @(negedge clk);
      valid = 1'b0;
   endtask
`endif

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0 && sb[0].t < $time) begin
         checks++;
         errors++;
         e = sb.pop_front();
         $display("FAIL missing_write: x%0d=%h due at %0t, no write observed by %0t",
                  e.waddr, e.wdata, e.t, $time);
      end
      if (sb.size() != 0 && sb[0].t == $time) begin
         e = sb.pop_front();
         chk("wen", 32'(reg_wen_o), 32'(e.wen));
         chk("waddr", 32'(reg_waddr_o), 32'(e.waddr));
         chk("wdata", reg_wdata_o, e.wdata);
      end else begin
         chk("no_write", 32'(reg_wen_o), 32'd0);
      end
   end

   initial begin
      add_vec(enc_i(12'hFFB, 3'b000, 5'd1),  32'h0,        32'hDEADBEEF, 1, 1, 32'hFFFFFFFB);
      add_vec(enc_r(7'h20, 3'b000, 5'd4),    32'd3,        32'd5,        1, 1, 32'hFFFFFFFE);
      add_vec(enc_r(7'h00, 3'b011, 5'd5),    32'd1,        32'hFFFFFFFF, 1, 1, 32'd1);
      add_vec(enc_i(12'h404, 3'b101, 5'd2),  32'h80000000, 32'h0,        1, 1, 32'hF8000000);
      add_vec(enc_i(12'h004, 3'b101, 5'd2),  32'h80000000, 32'h0,        1, 1, 32'h08000000);
      add_vec(enc_r(7'h00, 3'b000, 5'd0),    32'd7,        32'd8,        1, 0, 32'd15);
      add_vec(32'h0000007F,                  32'd1,        32'd2,        0, 0, 32'd0);
      add_vec(enc_i(12'hFFF, 3'b010, 5'd6),  32'd5,        32'h0,        1, 1, 32'd0);
      add_vec(enc_i(12'hFFF, 3'b010, 5'd6),  32'hFFFFFFFE, 32'h0,        1, 1, 32'd1);
      add_vec(enc_i(12'hFFF, 3'b011, 5'd7),  32'd5,        32'h0,        1, 1, 32'd1);
      add_vec(enc_i(12'h0F0, 3'b100, 5'd8),  32'h0000FFFF, 32'h0,        1, 1, 32'h0000FF0F);
      add_vec(enc_i(12'h800, 3'b110, 5'd9),  32'h12,       32'h0,        1, 1, 32'hFFFFF812);
      add_vec(enc_i(12'h7FF, 3'b111, 5'd10), 32'hFFFFFFFF, 32'h0,        1, 1, 32'h000007FF);
      add_vec(enc_i(12'h01F, 3'b001, 5'd11), 32'd3,        32'h0,        1, 1, 32'h80000000);
      add_vec(enc_r(7'h00, 3'b001, 5'd12),   32'd1,        32'h24,       1, 1, 32'h10);
      add_vec(enc_r(7'h00, 3'b010, 5'd13),   32'h80000000, 32'd1,        1, 1, 32'd1);
      add_vec(enc_r(7'h00, 3'b010, 5'd13),   32'd1,        32'h80000000, 1, 1, 32'd0);
      add_vec(enc_r(7'h00, 3'b100, 5'd14),   32'hF0F0F0F0, 32'hFFFF0000, 1, 1, 32'h0F0FF0F0);
      add_vec(enc_r(7'h00, 3'b101, 5'd15),   32'h80000000, 32'd31,       1, 1, 32'd1);
      add_vec(enc_r(7'h20, 3'b101, 5'd16),   32'h80000000, 32'd31,       1, 1, 32'hFFFFFFFF);
      add_vec(enc_r(7'h00, 3'b110, 5'd17),   32'h00FF0000, 32'h000000FF, 1, 1, 32'h00FF00FF);
      add_vec(enc_r(7'h00, 3'b111, 5'd18),   32'hFF00FF00, 32'h0FF00FF0, 1, 1, 32'h0F000F00);
      add_vec(enc_r(7'h00, 3'b000, 5'd19),   32'hFFFFFFFF, 32'd2,        1, 1, 32'd1);
      add_vec(enc_r(7'h20, 3'b001, 5'd20),   32'd1,        32'd1,        0, 0, 32'd0);
      add_vec(enc_i(12'h401, 3'b001, 5'd20), 32'd1,        32'd0,        0, 0, 32'd0);
      add_vec(enc_r(7'h00, 3'b011, 5'd5),    32'hFFFFFFFF, 32'd1,        1, 1, 32'd0);

      @(negedge clk);
      chk("rst_wen", 32'(reg_wen_o), 32'd0);
      chk("rst_waddr", 32'(reg_waddr_o), 32'd0);
      chk("rst_wdata", reg_wdata_o, 32'd0);
      chk("rst_ready", 32'(inst_ready_o), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      foreach (vecs[k]) begin
         issue(vecs[k].inst, vecs[k].op1, vecs[k].op2, vecs[k].push, vecs[k].wen,
               vecs[k].wdata);
      end
      valid = 1'b0;
      @(negedge clk);

`ifdef MUL_EXT_EN
      issue(enc_r(7'h01, 3'b001, 5'd26), 32'd3, 32'd4, 0, 0, 32'd0);
      valid = 1'b0;
      chk("ready_after_mulh", 32'(inst_ready_o), 32'd1);
      do_mul(32'h00012345, 32'h00010000, 5'd21);
      do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd25);
      do_mul($urandom, $urandom, 5'd27);
      do_mul(32'd7, 32'd6, 5'd0);
`else
      issue(enc_r(7'h01, 3'b000, 5'd26), 32'd3, 32'd4, 0, 0, 32'd0);
      valid = 1'b0;
      chk("ready_after_mul_enc", 32'(inst_ready_o), 32'd1);
`endif

      // Leave non-zero outputs behind, then reset (mid-multiply when the multiplier exists).
      issue(enc_i(12'h055, 3'b000, 5'd24), 32'd0, 32'd0, 1, 1, 32'h55);
`ifdef MUL_EXT_EN
      inst  = enc_r(7'h01, 3'b000, 5'd28);
      op1   = 32'hFFFF;
      op2   = 32'hFFFF;
      valid = 1'b1;
      @(posedge clk);
      repeat (10) @(negedge clk);
`endif
      valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("arst_wen", 32'(reg_wen_o), 32'd0);
      chk("arst_waddr", 32'(reg_waddr_o), 32'd0);
      chk("arst_wdata", reg_wdata_o, 32'd0);
      chk("arst_ready", 32'(inst_ready_o), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      issue(enc_i(12'h123, 3'b000, 5'd23), 32'd0, 32'd9, 1, 1, 32'h123);
      valid = 1'b0;

      repeat (40) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
